tt_scanner: RTL
===============

TT_SCANNER -- requirements
Module: tt_scanner

Interface
REQ-001 Parameter N, default 4: number of inputs driven into the device under test (DUT); legal range 1..8.
REQ-002 Parameter HOLD, default 2: clock cycles each input vector is held before sampling; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a full sweep; sampled only in IDLE.
REQ-006 f  input  1  DUT response to vec.
REQ-007 expect  input  2^N  golden minterm mask; sampled in the DONE cycle.
REQ-008 vec  output  N  input vector driven into the DUT; registered.
REQ-009 busy  output  1  high while a sweep is in progress (SCAN state).
REQ-010 done  output  1  one-cycle pulse marking sweep completion.
REQ-011 mask  output  2^N  captured truth table; bit i holds f for vec==i.
REQ-012 ones  output  N+1  count of minterms where f==1.
REQ-013 mismatch  output  1  registered (mask != expect); updated in the DONE cycle.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and DONE, encoded in 2 bits.
REQ-015 IDLE with start=1 SHALL go to SCAN and, on the same edge, clear vec, mask, ones, mismatch and the hold counter.
REQ-016 IDLE with start=0 SHALL stay in IDLE and hold all outputs.
REQ-017 In SCAN, the hold counter SHALL count 0..HOLD-1 while vec is held constant.
REQ-018 On the cycle where the hold counter equals HOLD-1, the block SHALL write f into mask[vec] and SHALL add f to ones.
REQ-019 On that same cycle, if vec < 2^N-1, vec SHALL increment by 1 and the hold counter SHALL return to 0.
REQ-020 On that same cycle, if vec == 2^N-1, the FSM SHALL go to DONE and vec SHALL hold at 2^N-1; vec SHALL never wrap past 2^N-1 within a sweep.
REQ-021 DONE SHALL last exactly one cycle: done=1, mismatch <= (mask != expect), then the FSM SHALL return to IDLE.
REQ-022 Latency: with start sampled at edge t, done SHALL be high during cycle t + 2^N*HOLD + 1.
REQ-023 busy SHALL be 1 exactly in SCAN and SHALL be 0 in IDLE and DONE.
REQ-024 start asserted in SCAN or DONE SHALL be ignored, with no restart and no queuing.
REQ-025 start held continuously SHALL begin a new sweep in the IDLE cycle after DONE.
REQ-026 mask, ones and mismatch SHALL hold their last values in IDLE until the next accepted start.
REQ-027 ones SHALL never exceed 2^N; N+1 bits SHALL suffice with no saturation logic.
REQ-028 With HOLD=1, a new vector SHALL be driven and sampled every cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, vec=0, busy=0, done=0, mask=0, ones=0, mismatch=0, hold counter=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep, with no done pulse and no partial result retained.
REQ-031 After rst_n deasserts, the block SHALL take no action until a start is accepted.

Verification (N=4, HOLD=2 unless stated)
REQ-032 Scenario 1: f = &vec, expect=16'h8000, start one cycle -> done 33 cycles after start; mask=16'h8000, ones=1, mismatch=0.
REQ-033 Scenario 2: f tied 1, expect=16'h0000 -> mask=16'hFFFF, ones=16, mismatch=1.
REQ-034 Scenario 3: f = vec[0]^vec[3], HOLD=1 -> mask=16'h55AA (bit i = i[0]^i[3]), ones=8, done 17 cycles after start.
REQ-035 Scenario 4: start pulsed at vec=5 during a sweep -> no restart; vec continues to 6; exactly one done pulse.
REQ-036 Scenario 5: rst_n low while vec=9 -> all outputs 0 asynchronously, no done; a new start after release runs a full correct sweep.
REQ-037 Scenario 6: start held high across two sweeps -> two done pulses separated by 2^N*HOLD+2 cycles, with identical mask on both.

Source files
------------

// File: rtl/tt_scanner.sv
// Exhaustive truth-table scanner: sweeps every N-bit input vector, holds each
// for HOLD cycles, captures the DUT response into a minterm mask and checks it.
module tt_scanner #(
  parameter int N    = 4,
  parameter int HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              f,
  // "expect" is a reserved SystemVerilog keyword, hence the suffix.
  input  logic [2**N-1:0]   expect_mask,
  output logic [N-1:0]      vec,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   mask,
  output logic [N:0]        ones,
  output logic              mismatch
);

  localparam int              CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);
  localparam logic [N-1:0]    VEC_LAST = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [N-1:0]      vec_reg, vec_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [2**N-1:0]   mask_reg, mask_next;
  logic [N:0]        ones_reg, ones_next;
  logic              mismatch_reg, mismatch_next;

  logic              accept;
  logic              sample;

  assign accept = (state_reg == IDLE) && start;
  assign sample = (state_reg == SCAN) && (cnt_reg == CNT_LAST);

  // Each mask bit only ever listens to its own minterm address.
  genvar gi;
  generate
    for (gi = 0; gi < 2**N; gi++) begin : g_mask
      always_comb begin
        mask_next[gi] = mask_reg[gi];
        if (accept)
          mask_next[gi] = 1'b0;
        else if (sample && (vec_reg == N'(gi)))
          mask_next[gi] = f;
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    vec_next      = vec_reg;
    cnt_next      = cnt_reg;
    ones_next     = ones_reg;
    mismatch_next = mismatch_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = SCAN;
          vec_next      = '0;
          cnt_next      = '0;
          ones_next     = '0;
          mismatch_next = 1'b0;
        end
      end
      SCAN: begin
        if (cnt_reg == CNT_LAST) begin
          ones_next = ones_reg + {{N{1'b0}}, f};
          // The last vector stays on the bus; the sweep never wraps.
          if (vec_reg == VEC_LAST) begin
            state_next = DONE;
          end else begin
            vec_next = vec_reg + 1'b1;
            cnt_next = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        mismatch_next = (mask_reg != expect_mask);
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      vec_reg      <= '0;
      cnt_reg      <= '0;
      mask_reg     <= '0;
      ones_reg     <= '0;
      mismatch_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      vec_reg      <= vec_next;
      cnt_reg      <= cnt_next;
      mask_reg     <= mask_next;
      ones_reg     <= ones_next;
      mismatch_reg <= mismatch_next;
    end
  end

  assign vec      = vec_reg;
  assign busy     = (state_reg == SCAN);
  assign done     = (state_reg == DONE);
  assign mask     = mask_reg;
  assign ones     = ones_reg;
  assign mismatch = mismatch_reg;

endmodule
